// File: rtl/bank_requester_if.sv
// rtl/bank_requester_if.sv - core request/response and bank access signal bundle
// master is the requester's view; slave is the core-plus-bank environment's view.
interface bank_requester_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;

    logic [ADDR_W-1:0] bank_addr;
    logic [DATA_W-1:0] bank_data_in;
    logic              bank_read_enable;
    logic              bank_write_enable;
    logic [DATA_W-1:0] bank_data_out;
    logic              bank_valid_out;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              busy;

    modport master (
        input  req_valid, req_we, req_addr, req_data,
        input  bank_data_out, bank_valid_out, rsp_ready,
        output req_ready, bank_addr, bank_data_in, bank_read_enable, bank_write_enable,
        output rsp_valid, rsp_data, rsp_err, busy
    );

    modport slave (
        output req_valid, req_we, req_addr, req_data,
        output bank_data_out, bank_valid_out, rsp_ready,
        input  req_ready, bank_addr, bank_data_in, bank_read_enable, bank_write_enable,
        input  rsp_valid, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/bank_requester.sv
// rtl/bank_requester.sv - queued single-outstanding bank initiator with timeout watchdog
// Requests are popped only in IDLE, so a read in flight blocks all later bank traffic.
module bank_requester #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 8
) (
    input  logic            clk,
    input  logic            reset,
    bank_requester_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam int ENT_W = 1 + ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WR, RD, WAIT, RESP} state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;

    logic [ENT_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr, rd_ptr;
    logic               empty, full, push, pop;
    logic               head_we;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_data;

    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  din_q, din_d;
    logic               re_q, re_d, we_q, we_d;
    logic               rv_q, rv_d, err_q, err_d;
    logic [DATA_W-1:0]  rdat_q, rdat_d;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push  = bus.req_valid && !full;
    assign pop   = (state == IDLE) && !empty;
    assign {head_we, head_addr, head_data} = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= {bus.req_we, bus.req_addr, bus.req_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: if (!empty) state_d = head_we ? WR : RD;
            WR:   state_d = IDLE;
            RD: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (bus.bank_valid_out || cnt == CNT_LAST) state_d = RESP;
                else                                      cnt_d   = cnt + 1'b1;
            end
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the registered outputs; strobes are computed one state early.
    always_comb begin
        addr_d = addr_q;
        din_d  = din_q;
        re_d   = 1'b0;
        we_d   = 1'b0;
        rv_d   = rv_q;
        rdat_d = rdat_q;
        err_d  = err_q;
        case (state)
            IDLE: begin
                if (!empty) begin
                    addr_d = head_addr;
                    if (head_we) begin
                        we_d  = 1'b1;
                        din_d = head_data;
                    end else begin
                        re_d  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (bus.bank_valid_out) begin
                    rv_d   = 1'b1;
                    rdat_d = bus.bank_data_out;
                    err_d  = 1'b0;
                end else if (cnt == CNT_LAST) begin
                    rv_d   = 1'b1;
                    rdat_d = '0;
                    err_d  = 1'b1;
                end
            end
            RESP: if (bus.rsp_ready) rv_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            addr_q <= '0;
            din_q  <= '0;
            re_q   <= 1'b0;
            we_q   <= 1'b0;
            rv_q   <= 1'b0;
            rdat_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            addr_q <= addr_d;
            din_q  <= din_d;
            re_q   <= re_d;
            we_q   <= we_d;
            rv_q   <= rv_d;
            rdat_q <= rdat_d;
            err_q  <= err_d;
        end
    end

    assign bus.req_ready         = !full;
    assign bus.bank_addr         = addr_q;
    assign bus.bank_data_in      = din_q;
    assign bus.bank_read_enable  = re_q;
    assign bus.bank_write_enable = we_q;
    assign bus.rsp_valid         = rv_q;
    assign bus.rsp_data          = rdat_q;
    assign bus.rsp_err           = err_q;
    assign bus.busy              = !empty || (state != IDLE);
endmodule

// File: tb/tb_bank_requester.sv
// tb/tb_bank_requester.sv - directed bench for bank_requester with a 1-cycle bank model
// Bank model can be silenced (timeout) or forced to strobe valid (stray strobes).
module tb_bank_requester;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bank_requester_if #(.ADDR_W(8), .DATA_W(8)) bif ();

    bank_requester #(.ADDR_W(8), .DATA_W(8), .FIFO_DEPTH(4), .TIMEOUT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.master)
    );

    logic [7:0] bmem [256];
    logic       bank_dead = 1'b0;
    logic       inject    = 1'b0;
    logic       bvalid_q  = 1'b0;
    logic [7:0] bdata_q   = 8'd0;

    always @(posedge clk) begin
        bvalid_q <= bif.bank_read_enable && !bank_dead;
        if (bif.bank_read_enable)  bdata_q <= bmem[bif.bank_addr];
        if (bif.bank_write_enable) bmem[bif.bank_addr] <= bif.bank_data_in;
    end
    assign bif.bank_valid_out = bvalid_q | inject;
    assign bif.bank_data_out  = bdata_q;

    int         overlap = 0;
    int         resp_strobe = 0;
    int         wcount = 0;
    logic [7:0] waddr = 8'd0;
    logic [7:0] wdata = 8'd0;

    always @(negedge clk) begin
        if (bif.bank_read_enable && bif.bank_write_enable) overlap++;
        if (bif.rsp_valid && (bif.bank_read_enable || bif.bank_write_enable)) resp_strobe++;
        if (bif.bank_write_enable) begin
            wcount++;
            waddr = bif.bank_addr;
            wdata = bif.bank_data_in;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic we, input logic [7:0] addr, input logic [7:0] data);
        int n = 0;
        @(negedge clk);
        bif.req_valid = 1'b1;
        bif.req_we    = we;
        bif.req_addr  = addr;
        bif.req_data  = data;
        while (!bif.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_cmp++;
            n_bad++;
            $error("FAIL push_timeout: observed req_ready 0 expected 1");
        end
        @(posedge clk);
        #1 bif.req_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [7:0] d, output logic e, output int lat);
        logic prior;
        lat = 0;
        while (!bif.rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bif.rsp_valid) begin
            n_cmp++;
            n_bad++;
            $error("FAIL rsp_timeout: observed rsp_valid 0 expected 1");
        end
        d = bif.rsp_data;
        e = bif.rsp_err;
        prior = bif.rsp_ready;
        bif.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bif.rsp_ready = prior;
    endtask

    logic       we_t   [4];
    logic [7:0] addr_t [4];
    logic [7:0] data_t [4];
    logic [7:0] exp_t  [3];

    initial begin
        logic [7:0] d;
        logic       e;
        int         lat;
        int         seen;

        bif.req_valid = 1'b0;
        bif.req_we    = 1'b0;
        bif.req_addr  = 8'd0;
        bif.req_data  = 8'd0;
        bif.rsp_ready = 1'b0;
        we_t   = '{1'b1, 1'b0, 1'b1, 1'b0};
        addr_t = '{8'd10, 8'd10, 8'd11, 8'd11};
        data_t = '{8'd55, 8'd0, 8'd66, 8'd0};
        exp_t  = '{8'd55, 8'd66, 8'd98};

        // 1: reset state, then reset while waiting on a silent bank
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(bif.req_ready), 1);
        chk("rst_busy", 32'(bif.busy), 0);
        chk("rst_re", 32'(bif.bank_read_enable), 0);
        chk("rst_we", 32'(bif.bank_write_enable), 0);
        chk("rst_rsp_valid", 32'(bif.rsp_valid), 0);
        chk("rst_bank_addr", 32'(bif.bank_addr), 0);
        bank_dead = 1'b1;
        push(1'b0, 8'd9, 8'd0);
        repeat (4) @(posedge clk);
        #1 chk("wait_busy", 32'(bif.busy), 1);
        reset = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(bif.rsp_valid), 0);
        chk("midrst_busy", 32'(bif.busy), 0);
        chk("midrst_req_ready", 32'(bif.req_ready), 1);
        @(negedge clk);
        reset = 1'b1;
        bank_dead = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bif.rsp_valid) seen++;
        end
        chk("midrst_no_rsp", 32'(seen), 0);

        // 2: write then read, read latency
        push(1'b1, 8'd9, 8'd24);
        repeat (3) @(posedge clk);
        #1;
        chk("wr_count", 32'(wcount), 1);
        chk("wr_addr", 32'(waddr), 9);
        chk("wr_data", 32'(wdata), 24);
        push(1'b0, 8'd9, 8'd0);
        get_rsp(d, e, lat);
        chk("rd_latency", 32'(lat), 3);
        chk("rd_data", 32'(d), 24);
        chk("rd_err", 32'(e), 0);
        chk("rd_consumed", 32'(bif.rsp_valid), 0);

        // 3: back-to-back writes and reads, in-order responses
        bif.rsp_ready = 1'b1;
        push(1'b1, 8'd255, 8'd145);
        push(1'b1, 8'd9, 8'd98);
        push(1'b0, 8'd255, 8'd0);
        push(1'b0, 8'd9, 8'd0);
        get_rsp(d, e, lat);
        chk("b2b_rsp0", 32'(d), 145);
        get_rsp(d, e, lat);
        chk("b2b_rsp1", 32'(d), 98);
        chk("b2b_err", 32'(e), 0);
        chk("b2b_wcount", 32'(wcount), 3);
        bif.rsp_ready = 1'b0;

        // 4: stalled response backs up the FIFO
        push(1'b0, 8'd255, 8'd0);
        lat = 0;
        while (!bif.rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("stall_rsp_valid", 32'(bif.rsp_valid), 1);
        for (int i = 0; i < 4; i++) begin
            push(we_t[i], addr_t[i], data_t[i]);
            chk("stall_hold_data", 32'(bif.rsp_data), 145);
        end
        @(negedge clk);
        bif.req_valid = 1'b1;
        bif.req_we    = 1'b0;
        bif.req_addr  = 8'd9;
        chk("stall_full", 32'(bif.req_ready), 0);
        @(posedge clk);
        #1 bif.req_valid = 1'b0;
        chk("stall_still_valid", 32'(bif.rsp_valid), 1);
        get_rsp(d, e, lat);
        chk("stall_rsp", 32'(d), 145);
        push(1'b0, 8'd9, 8'd0);
        for (int i = 0; i < 3; i++) begin
            get_rsp(d, e, lat);
            chk("drain_rsp", 32'(d), 32'(exp_t[i]));
        end
        repeat (3) @(negedge clk);
        chk("drain_req_ready", 32'(bif.req_ready), 1);
        chk("drain_busy", 32'(bif.busy), 0);

        // 5: timeout, then recovery
        bank_dead = 1'b1;
        push(1'b0, 8'd9, 8'd0);
        get_rsp(d, e, lat);
        chk("to_latency", 32'(lat), 10);
        chk("to_data", 32'(d), 0);
        chk("to_err", 32'(e), 1);
        bank_dead = 1'b0;
        push(1'b0, 8'd9, 8'd0);
        get_rsp(d, e, lat);
        chk("rec_data", 32'(d), 98);
        chk("rec_err", 32'(e), 0);
        chk("rec_latency", 32'(lat), 3);

        // 6: stray valid strobes, then reads across the pointer wrap
        @(negedge clk);
        inject = 1'b1;
        repeat (2) @(negedge clk);
        inject = 1'b0;
        @(negedge clk);
        chk("stray_idle_rsp", 32'(bif.rsp_valid), 0);
        chk("stray_idle_busy", 32'(bif.busy), 0);
        push(1'b1, 8'd0, 8'd77);
        push(1'b0, 8'd0, 8'd0);
        lat = 0;
        while (!bif.rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        inject = 1'b1;
        repeat (2) @(posedge clk);
        #1 inject = 1'b0;
        chk("stray_resp_valid", 32'(bif.rsp_valid), 1);
        chk("stray_resp_data", 32'(bif.rsp_data), 77);
        get_rsp(d, e, lat);
        chk("stray_resp_rsp", 32'(d), 77);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (bif.rsp_valid) seen++;
        end
        chk("stray_no_extra", 32'(seen), 0);
        push(1'b0, 8'd0, 8'd0);
        push(1'b0, 8'd0, 8'd0);
        push(1'b0, 8'd0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            get_rsp(d, e, lat);
            chk("wrap_rsp", 32'(d), 77);
            chk("wrap_err", 32'(e), 0);
        end
        repeat (3) @(negedge clk);
        chk("end_busy", 32'(bif.busy), 0);
        chk("strobe_overlap", 32'(overlap), 0);
        chk("strobe_in_resp", 32'(resp_strobe), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bank_requester.md
Name: bank_requester

Overview:
- Initiator side of the bank access interface. Sits between a GPU core and one `bank` memory instance.
- Buffers core read/write requests in a small FIFO and issues them to the bank one at a time.
- For reads, waits for the bank's valid strobe and returns the read data to the core over a valid/ready response channel.
- A timeout watchdog turns a missing bank response into an error response instead of a hang.

Parameters:
- ADDR_W, 8, bank address width.
- DATA_W, 8, bank data width.
- FIFO_DEPTH, 4, request FIFO entries; must be a power of 2, at least 2.
- TIMEOUT, 8, maximum cycles spent in WAIT before an error response; must be at least 2.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  request accepted when req_valid && req_ready at a clk edge.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_data  in  DATA_W  write data; ignored for reads.
- bank_addr  out  ADDR_W  address to the bank.
- bank_data_in  out  DATA_W  write data to the bank.
- bank_read_enable  out  1  one-cycle read strobe.
- bank_write_enable  out  1  one-cycle write strobe.
- bank_data_out  in  DATA_W  read data from the bank.
- bank_valid_out  in  1  bank read data valid.
- rsp_valid  out  1  read response valid.
- rsp_ready  in  1  core accepts the response.
- rsp_data  out  DATA_W  read data; 0 on error.
- rsp_err  out  1  1 = bank timed out.
- busy  out  1  FIFO non-empty or FSM not in IDLE.

Behaviour:
- Reset (reset=0, asynchronous), all immediate:
  - FIFO emptied, FSM to IDLE, timeout counter cleared.
  - bank_read_enable, bank_write_enable, rsp_valid, rsp_err, busy all 0.
  - bank_addr, bank_data_in, rsp_data all 0.
  - req_ready = 1.
  - Reset mid-transaction drops all queued and in-flight requests with no response.
- Request FIFO:
  - req_ready = !full. There is no bypass: a push when full is impossible, even if a pop happens in the same cycle.
  - Push and pop in the same cycle are both allowed when not full.
  - Pointers wrap modulo FIFO_DEPTH; order is strictly preserved.
- All bank-side and response outputs are registered.
- FSM states: IDLE, WR, RD, WAIT, RESP.
  - IDLE: if the FIFO is non-empty, pop the head into the command registers and go to WR (req_we=1) or RD (req_we=0). Otherwise stay in IDLE.
  - WR: bank_write_enable=1 for exactly one cycle, with bank_addr and bank_data_in from the command. Next state IDLE.
    - Writes are posted: no response is generated.
    - Sustained write throughput is one write per 2 cycles.
  - RD: bank_read_enable=1 for exactly one cycle, with bank_addr. Next state WAIT, counter := 0.
  - WAIT: bank_valid_out is sampled every cycle.
    - If it is 1: rsp_data := bank_data_out, rsp_err := 0, go to RESP.
    - Otherwise, if counter == TIMEOUT-1: rsp_data := 0, rsp_err := 1, go to RESP.
    - Otherwise counter += 1. Counter width is clog2(TIMEOUT).
  - RESP: rsp_valid=1. rsp_data and rsp_err are held stable until rsp_ready=1 at an edge; then go to IDLE.
    - No new bank access is issued while in RESP; reads are strictly one outstanding.
- bank_valid_out is ignored in IDLE, WR, RD and RESP; stray strobes have no effect.
- Strobes are deasserted in every state except their own. bank_read_enable and bank_write_enable are never high together.
- bank_addr and bank_data_in hold their last driven value when no strobe is asserted.
- Latency with a 1-cycle bank:
  - Read accepted at edge E0 → pop at E1 → read strobe high between E1 and E2 → bank valid between E2 and E3 → rsp_valid high after E3.
  - So rsp_valid rises 3 cycles after acceptance.
  - A write reaches the bank strobe 1 cycle after acceptance.
- Read-after-write to the same address: the write strobe always precedes the read strobe by at least one cycle, so the read returns the new data.

Test Plan:
1. After reset release with the FIFO empty → req_ready=1, busy=0, both strobes 0, rsp_valid=0. Assert reset in WAIT → rsp_valid stays 0 and busy=0 immediately.
2. Write addr 9 data 24, then read addr 9 → bank_write_enable pulses once with addr 9 data 24. The read yields rsp_valid=1, rsp_data=24, rsp_err=0, exactly 3 cycles after read acceptance.
3. Back-to-back: write 255/145, write 9/98, read 255, read 9 with rsp_ready=1 → responses 145 then 98 in order. Strobes are never high together.
4. Hold rsp_ready=0 for 5 cycles while pushing 5 more requests → req_ready drops after 4 accepted. rsp_data is stable the whole time. No bank strobe while in RESP. Draining restores req_ready=1.
5. Bank model never asserts valid → rsp_valid=1, rsp_err=1, rsp_data=0 exactly TIMEOUT (8) cycles after entering WAIT. The next read of addr 9 with a working bank returns 98, rsp_err=0.
6. Inject bank_valid_out=1 in IDLE and RESP → no state change and no extra response. Issue 3 consecutive reads to addr 0 → the FIFO pointer wrap is exercised and every response is correct.
